result_serializer: RTL and testbench

- Sits directly downstream of the nonce decoder.
- Captures each per-block result (valid strobe, success flag, 32-bit nonce) into a small FIFO and serializes it as a byte frame to the host link over a valid/ready handshake.
- Decouples the decoder's one-cycle result strobe from a host interface that may stall arbitrarily.

---
 rtl/result_serializer.sv | 137 +++++++++++++
 tb/tb_result_serializer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_serializer.sv
// Buffers decoder results in a small FIFO and streams each one to the host
// as a header byte, optionally followed by the 4 nonce bytes MSB first.
module result_serializer #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [7:0]  HDR_FOUND  = 8'hA5,
    parameter logic [7:0]  HDR_NONE   = 8'h5A
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 valid_i,
    input  logic                                 success_i,
    input  logic [31:0]                          nonce_i,
    input  logic                                 ready_i,
    output logic                                 valid_o,
    output logic [7:0]                           data_o,
    output logic                                 overflow_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count_o,
    output logic [15:0]                          frame_cnt_o
);

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned ENTRY_W = 33;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        B3   = 3'd2,
        B2   = 3'd3,
        B1   = 3'd4,
        B0   = 3'd5
    } state_t;

    state_t             state;
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               frame_success;
    logic [31:0]        frame_nonce;

    logic               accept_c;
    logic               frame_done_c;
    logic               fifo_empty_c;
    logic               fifo_full_c;
    logic               pop_c;
    logic               push_c;
    logic [ENTRY_W-1:0] head_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake, frame completion and FIFO push/pop decisions for this cycle.
    always_comb begin
        accept_c     = valid_o && ready_i;
        frame_done_c = accept_c && (((state == HDR) && !frame_success) || (state == B0));
        fifo_empty_c = (fifo_count_o == '0);
        fifo_full_c  = (fifo_count_o == CNT_W'(FIFO_DEPTH));
        pop_c        = !fifo_empty_c && ((state == IDLE) || frame_done_c);
        push_c       = valid_i && (!fifo_full_c || pop_c);
        head_c       = mem[rd_ptr];
    end

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= {success_i, nonce_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count_o  <= '0;
            overflow_o    <= 1'b0;
            frame_cnt_o   <= 16'd0;
            frame_success <= 1'b0;
            frame_nonce   <= 32'd0;
            valid_o       <= 1'b0;
            data_o        <= 8'd0;
        end else begin
            if (push_c) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_c) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_c, pop_c})
                2'b10:   fifo_count_o <= fifo_count_o + CNT_W'(1);
                2'b01:   fifo_count_o <= fifo_count_o - CNT_W'(1);
                default: fifo_count_o <= fifo_count_o;
            endcase
            if (valid_i && fifo_full_c && !pop_c) begin
                overflow_o <= 1'b1;
            end
            if (frame_done_c) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
            end

            // Loading a new frame takes priority so frames run back-to-back.
            if (pop_c) begin
                frame_success <= head_c[32];
                frame_nonce   <= head_c[31:0];
                state         <= HDR;
                valid_o       <= 1'b1;
                data_o        <= head_c[32] ? HDR_FOUND : HDR_NONE;
            end else if (frame_done_c) begin
                state   <= IDLE;
                valid_o <= 1'b0;
                data_o  <= 8'd0;
            end else if (accept_c) begin
                case (state)
                    HDR: begin
                        state  <= B3;
                        data_o <= frame_nonce[31:24];
                    end
                    B3: begin
                        state  <= B2;
                        data_o <= frame_nonce[23:16];
                    end
                    B2: begin
                        state  <= B1;
                        data_o <= frame_nonce[15:8];
                    end
                    B1: begin
                        state  <= B0;
                        data_o <= frame_nonce[7:0];
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench for result_serializer: expected bytes are queued at
// stimulus time and consumed by a monitor on every accepted byte.
module tb_result_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        success_i;
    logic [31:0] nonce_i;
    logic        ready_i;
    logic        valid_o;
    logic [7:0]  data_o;
    logic        overflow_o;
    logic [1:0]  fifo_count_o;
    logic [15:0] frame_cnt_o;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_q[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data  = 8'd0;
    logic [7:0]  exp_byte;

    always #5 clk = ~clk;

    result_serializer #(
        .FIFO_DEPTH(2),
        .HDR_FOUND (8'hA5),
        .HDR_NONE  (8'h5A)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .success_i   (success_i),
        .nonce_i     (nonce_i),
        .ready_i     (ready_i),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .overflow_o  (overflow_o),
        .fifo_count_o(fifo_count_o),
        .frame_cnt_o (frame_cnt_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic s, input logic [31:0] n);
        valid_i   = 1'b1;
        success_i = s;
        nonce_i   = n;
    endtask

    task automatic idle_in();
        valid_i   = 1'b0;
        success_i = 1'bx;
        nonce_i   = 32'hxxxx_xxxx;
    endtask

    task automatic exp_frame(input logic s, input logic [31:0] n);
        if (s) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(n[31:24]);
            exp_q.push_back(n[23:16]);
            exp_q.push_back(n[15:8]);
            exp_q.push_back(n[7:0]);
        end else begin
            exp_q.push_back(8'h5A);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !valid_o) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: drain timeout, %0d bytes outstanding", name, exp_q.size());
    endtask

    // Monitor: stall stability and in-order byte comparison at each accept.
    always @(negedge clk) begin
        if (prev_stall) begin
            check("hold_valid", 32'(valid_o), 32'd1);
            check("hold_data", 32'(data_o), 32'(prev_data));
        end
        if (rst && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %h expected none", data_o);
            end else begin
                exp_byte = exp_q.pop_front();
                check("byte", 32'(data_o), 32'(exp_byte));
            end
        end
        prev_stall = rst && valid_o && !ready_i;
        prev_data  = data_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    localparam logic [3:0] READY_PAT = 4'b1001;

    initial begin
        rst     = 1'b0;
        ready_i = 1'b0;
        idle_in();
        tick();
        tick();
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_overflow", 32'(overflow_o), 32'd0);
        check("rst_fifo_count", 32'(fifo_count_o), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
        rst = 1'b1;

        // 1: found frame, latency and byte order
        ready_i = 1'b1;
        strobe(1'b1, 32'hDEADBEEF);
        exp_frame(1'b1, 32'hDEADBEEF);
        tick();
        idle_in();
        check("s1_valid_t1", 32'(valid_o), 32'd0);
        check("s1_count_t1", 32'(fifo_count_o), 32'd1);
        tick();
        check("s1_valid_t2", 32'(valid_o), 32'd1);
        check("s1_hdr_t2", 32'(data_o), 32'hA5);
        for (int i = 0; i < 5; i++) tick();
        check("s1_frame_cnt", 32'(frame_cnt_o), 32'd1);
        check("s1_valid_end", 32'(valid_o), 32'd0);

        // 2: none frame is header only
        strobe(1'b0, 32'h12345678);
        exp_frame(1'b0, 32'h12345678);
        tick();
        idle_in();
        tick();
        check("s2_hdr", 32'(data_o), 32'h5A);
        tick();
        check("s2_valid_end", 32'(valid_o), 32'd0);
        check("s2_frame_cnt", 32'(frame_cnt_o), 32'd2);

        // 3: found frame under ready toggling 1,0,0,1
        strobe(1'b1, 32'hDEADBEEF);
        exp_frame(1'b1, 32'hDEADBEEF);
        tick();
        idle_in();
        for (int i = 0; i < 24; i++) begin
            ready_i = READY_PAT[3 - (i % 4)];
            tick();
        end
        ready_i = 1'b1;
        drain("s3_drain");
        check("s3_frame_cnt", 32'(frame_cnt_o), 32'd3);

        // 4: stalled host, FIFO fills, fourth strobe overflows
        tick();
        ready_i = 1'b0;
        strobe(1'b1, 32'd1);
        exp_frame(1'b1, 32'd1);
        tick();
        strobe(1'b1, 32'd2);
        exp_frame(1'b1, 32'd2);
        tick();
        strobe(1'b1, 32'd3);
        exp_frame(1'b1, 32'd3);
        tick();
        idle_in();
        check("s4_count_full", 32'(fifo_count_o), 32'd2);
        check("s4_no_overflow", 32'(overflow_o), 32'd0);
        strobe(1'b1, 32'd4);
        tick();
        idle_in();
        check("s4_overflow", 32'(overflow_o), 32'd1);
        check("s4_count_after_drop", 32'(fifo_count_o), 32'd2);
        ready_i = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("s4_stream_gap", 32'(valid_o), 32'd1);
        end
        tick();
        check("s4_valid_end", 32'(valid_o), 32'd0);
        check("s4_overflow_sticky", 32'(overflow_o), 32'd1);
        check("s4_frame_cnt", 32'(frame_cnt_o), 32'd6);
        check("s4_queue_empty", 32'(exp_q.size()), 32'd0);

        // 5: push while full coinciding with a frame-done pop
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("s5_rst_overflow", 32'(overflow_o), 32'd0);
        ready_i = 1'b0;
        strobe(1'b0, 32'h0000000A);
        exp_frame(1'b0, 32'h0000000A);
        tick();
        strobe(1'b1, 32'hCAFEF00D);
        exp_frame(1'b1, 32'hCAFEF00D);
        tick();
        strobe(1'b0, 32'h0000000C);
        exp_frame(1'b0, 32'h0000000C);
        tick();
        idle_in();
        check("s5_count_full", 32'(fifo_count_o), 32'd2);
        ready_i = 1'b1;
        strobe(1'b1, 32'h01020304);
        exp_frame(1'b1, 32'h01020304);
        tick();
        idle_in();
        check("s5_count_same", 32'(fifo_count_o), 32'd2);
        check("s5_no_overflow", 32'(overflow_o), 32'd0);
        check("s5_frame_cnt1", 32'(frame_cnt_o), 32'd1);
        drain("s5_drain");
        check("s5_frame_cnt", 32'(frame_cnt_o), 32'd4);
        check("s5_overflow_end", 32'(overflow_o), 32'd0);

        // 6: reset during B2 abandons the frame and flushes the FIFO
        tick();
        strobe(1'b1, 32'h11223344);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h11);
        tick();
        idle_in();
        tick();
        strobe(1'b1, 32'h55667788);
        tick();
        idle_in();
        tick();
        check("s6_b2_data", 32'(data_o), 32'h22);
        check("s6_count_mid", 32'(fifo_count_o), 32'd1);
        rst = 1'b0;
        tick();
        check("s6_rst_valid", 32'(valid_o), 32'd0);
        check("s6_rst_count", 32'(fifo_count_o), 32'd0);
        check("s6_rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
        check("s6_abandoned", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        strobe(1'b0, 32'h99999999);
        exp_frame(1'b0, 32'h99999999);
        tick();
        idle_in();
        tick();
        check("s6_fresh_hdr", 32'(data_o), 32'h5A);
        drain("s6_drain");
        check("s6_frame_cnt", 32'(frame_cnt_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
